// File: rtl/mips_lsu_pkg.sv
// Shared opcode constants, FSM states and decode helpers for the MIPS load/store unit.
package mips_lsu_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam int DMEM_SIZE = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Byte accesses can never be misaligned, so only word and halfword ops are tested.
    function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] offset);
        case (op)
            OP_LW, OP_SW:          return offset == 2'b00;
            OP_LH, OP_LHU, OP_SH:  return !offset[0];
            default:               return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// Big-endian byte-lane steering: store byte enables and replicated write data,
// plus selection and sign/zero extension of load data.
module lsu_lane
    import mips_lsu_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] rt,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

        // Loads and SW use all four lanes with the word passed straight through.
        be    = 4'b1111;
        wdata = rt;
        ext   = rdata;
        case (op)
            OP_SB: begin
                be    = 4'b1000 >> offset;
                wdata = {4{rt[7:0]}};
            end
            OP_SH: begin
                be    = offset[1] ? 4'b0011 : 4'b1100;
                wdata = {2{rt[15:0]}};
            end
            OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ext = {24'h000000, byte_sel};
            OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ext = {16'h0000, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// Load/store initiator: decodes the memory opcode, runs a req/ack transaction on the
// data-memory bus and stalls the pipeline until it completes or times out.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [31:0]       Ins,
    input  logic [31:0]       Result,
    input  logic [31:0]       Rdata2,
    output logic              stall,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic              align_err,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]       op_q;
    logic [1:0]       off_q;

    logic [5:0]  op_live;
    logic [1:0]  off_live;
    logic        start, misalign, timeout;
    logic [5:0]  lane_op;
    logic [1:0]  lane_off;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_ext;
    logic        unused_bits;

    assign op_live     = Ins[31:26];
    assign off_live    = Result[1:0];
    assign start       = in_valid && is_mem_op(op_live) && is_aligned(op_live, off_live);
    assign misalign    = in_valid && is_mem_op(op_live) && !is_aligned(op_live, off_live);
    assign timeout     = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign unused_bits = ^{Ins[25:0], Result[31:ADDR_W+2]};

    // The lane logic sees the live instruction while idle and the latched one afterwards.
    assign lane_op  = (state_q == ST_IDLE) ? op_live  : op_q;
    assign lane_off = (state_q == ST_IDLE) ? off_live : off_q;

    lsu_lane u_lane (
        .op     (lane_op),
        .offset (lane_off),
        .rt     (Rdata2),
        .rdata  (mem_rdata),
        .be     (lane_be),
        .wdata  (lane_wdata),
        .ext    (lane_ext)
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stall   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (mem_ack || timeout) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            ld_data   <= 32'h0;
            ld_valid  <= 1'b0;
            align_err <= 1'b0;
            bus_err   <= 1'b0;
            cnt_q     <= '0;
            op_q      <= 6'h0;
            off_q     <= 2'b00;
        end else begin
            ld_valid  <= 1'b0;
            align_err <= 1'b0;
            bus_err   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mem_req   <= 1'b1;
                        mem_we    <= !is_load(op_live);
                        mem_addr  <= Result[ADDR_W+1:2];
                        mem_be    <= lane_be;
                        mem_wdata <= lane_wdata;
                        op_q      <= op_live;
                        off_q     <= off_live;
                        cnt_q     <= '0;
                    end else if (misalign) begin
                        align_err <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // An ack in the final window cycle still wins over the timeout.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (is_load(op_q)) begin
                            ld_data  <= lane_ext;
                            ld_valid <= 1'b1;
                        end
                    end else if (timeout) begin
                        mem_req  <= 1'b0;
                        bus_err  <= 1'b1;
                        ld_data  <= 32'h0;
                        ld_valid <= is_load(op_q);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu: a transaction-timeline model sets per-cycle expectations
// that a negedge compare process checks, plus literal pins on captured values.
module tb_mips_lsu;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;

    logic              CLK = 1'b0;
    logic              RST;
    logic              in_valid;
    logic [31:0]       Ins, Result, Rdata2;
    logic              stall, ld_valid, align_err, bus_err;
    logic [31:0]       ld_data;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata, mem_rdata;

    always #5 CLK = ~CLK;

    mips_lsu #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .Ins       (Ins),
        .Result    (Result),
        .Rdata2    (Rdata2),
        .stall     (stall),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .align_err (align_err),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    bit          chk_en = 1'b0;
    logic        e_stall, e_req, e_we, e_ldv, e_align, e_bus;
    logic [9:0]  e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_ld;

    logic [31:0] cap_wdata, cap_ld;
    logic [3:0]  cap_be;
    logic [9:0]  cap_addr;
    int stall_cycles, req_cycles, ldv_count, align_count, bus_count;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            checkOutput("stall", 32'(stall), 32'(e_stall));
            checkOutput("mem_req", 32'(mem_req), 32'(e_req));
            checkOutput("ld_valid", 32'(ld_valid), 32'(e_ldv));
            checkOutput("align_err", 32'(align_err), 32'(e_align));
            checkOutput("bus_err", 32'(bus_err), 32'(e_bus));
            checkOutput("ld_data", ld_data, e_ld);
            if (e_req) begin
                checkOutput("mem_addr", 32'(mem_addr), 32'(e_addr));
                checkOutput("mem_we", 32'(mem_we), 32'(e_we));
                checkOutput("mem_be", 32'(mem_be), 32'(e_be));
                checkOutput("mem_wdata", mem_wdata, e_wdata);
            end
            if (mem_req) begin
                cap_addr  = mem_addr;
                cap_be    = mem_be;
                cap_wdata = mem_wdata;
                req_cycles++;
            end
            if (ld_valid) begin
                cap_ld = ld_data;
                ldv_count++;
            end
            if (stall)     stall_cycles++;
            if (align_err) align_count++;
            if (bus_err)   bus_count++;
        end
    end

    // Reference rules, phrased as access size and big-endian byte positions.
    function automatic int op_size(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [5:0] op);
        return (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
    endfunction

    function automatic logic [3:0] model_be(input logic [5:0] op, input logic [31:0] addr);
        logic [3:0] be;
        int off;
        if (op_load(op)) return 4'hF;
        be  = 4'h0;
        off = int'(addr % 4);
        for (int i = off; i < off + op_size(op); i++) be[3 - i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] rt);
        case (op_size(op))
            1:       return 32'(rt[7:0]) * 32'h01010101;
            2:       return 32'(rt[15:0]) * 32'h00010001;
            default: return rt;
        endcase
    endfunction

    function automatic logic [31:0] model_ld(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int size, off, shift;
        logic [31:0] v, mask;
        size  = op_size(op);
        off   = int'(addr % 4);
        shift = 8 * (4 - off - size);
        v     = rdata >> shift;
        if (size == 4) return v;
        mask = (32'd1 << (8 * size)) - 32'd1;
        v    = v & mask;
        if ((op == 6'h20 || op == 6'h21) && v[8 * size - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idleExp();
        e_stall = 1'b0; e_req = 1'b0; e_ldv = 1'b0; e_align = 1'b0; e_bus = 1'b0;
    endtask

    task automatic clearCounts();
        stall_cycles = 0; req_cycles = 0; ldv_count = 0; align_count = 0; bus_count = 0;
    endtask

    // One instruction: ack_at is the REQ-cycle index of the ack (-1 = never),
    // n_idle the idle cycles afterwards, late_ack the idle cycle carrying a stray ack.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                                 input logic [31:0] rt, input logic [31:0] rdata,
                                 input int ack_at, input int n_idle, input int late_ack);
        int  size;
        bit  aligned, tmo;
        size    = op_size(op);
        aligned = (size > 0) && ((addr % size) == 0);
        tmo     = (ack_at < 0) || (ack_at >= TIMEOUT);

        step();
        in_valid = 1'b1; Ins = {op, 26'h2ABCDEF}; Result = addr; Rdata2 = rt;
        mem_rdata = rdata; mem_ack = 1'b0;
        idleExp();
        e_stall = aligned;

        if (!aligned) begin
            step();
            in_valid = 1'b0;
            idleExp();
            e_align = (size > 0);
        end else begin
            for (int k = 0; k < TIMEOUT; k++) begin
                step();
                mem_ack = (k == ack_at);
                idleExp();
                e_stall = 1'b1; e_req = 1'b1;
                e_addr  = addr[11:2];
                e_we    = !op_load(op);
                e_be    = model_be(op, addr);
                e_wdata = model_wdata(op, rt);
                if (k == ack_at) break;
            end
            step();
            mem_ack = 1'b0;
            idleExp();
            e_ldv = op_load(op);
            e_bus = tmo;
            if (tmo)          e_ld = 32'h0;
            else if (e_ldv)   e_ld = model_ld(op, addr, rdata);
        end

        for (int j = 1; j <= n_idle; j++) begin
            step();
            in_valid = 1'b0;
            mem_ack  = (j == late_ack);
            idleExp();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b1; in_valid = 1'b0; Ins = 32'h0; Result = 32'h0; Rdata2 = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        e_ld = 32'h0; e_addr = '0; e_be = '0; e_we = 1'b0; e_wdata = '0;
        cap_wdata = '0; cap_ld = '0; cap_be = '0; cap_addr = '0;
        idleExp();
        clearCounts();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_be", 32'(mem_be), 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_ld_data", ld_data, 32'h0);
        checkOutput("rst_ld_valid", 32'(ld_valid), 32'h0);
        checkOutput("rst_stall", 32'(stall), 32'h0);
        step();
        chk_en = 1'b1;

        $display("[TB] SW 0x10");
        clearCounts();
        applyStimulus(6'h2B, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, 0);
        checkOutput("sw_addr_lit", 32'(cap_addr), 32'h4);
        checkOutput("sw_be_lit", 32'(cap_be), 32'hF);
        checkOutput("sw_wdata_lit", cap_wdata, 32'hDEADBEEF);
        checkOutput("sw_stall_cycles", 32'(stall_cycles), 32'd2);
        checkOutput("sw_no_ldv", 32'(ldv_count), 32'd0);

        $display("[TB] LB / LBU 0x13");
        clearCounts();
        applyStimulus(6'h20, 32'h13, 32'h0, 32'h000000F0, 0, 1, 0);
        checkOutput("lb_lit", cap_ld, 32'hFFFFFFF0);
        applyStimulus(6'h24, 32'h13, 32'h0, 32'h000000F0, 0, 1, 0);
        checkOutput("lbu_lit", cap_ld, 32'h000000F0);
        checkOutput("lb_lbu_ldv", 32'(ldv_count), 32'd2);

        $display("[TB] SH 0x2 / LH misaligned");
        applyStimulus(6'h29, 32'h2, 32'h1234ABCD, 32'h0, 0, 1, 0);
        checkOutput("sh_be_lit", 32'(cap_be), 32'h3);
        checkOutput("sh_wdata_lit", cap_wdata, 32'hABCDABCD);
        clearCounts();
        applyStimulus(6'h21, 32'h1, 32'h0, 32'h0, 0, 1, 0);
        checkOutput("lh_mis_align", 32'(align_count), 32'd1);
        checkOutput("lh_mis_noreq", 32'(req_cycles), 32'd0);
        checkOutput("lh_mis_nostall", 32'(stall_cycles), 32'd0);

        $display("[TB] extra lane patterns");
        applyStimulus(6'h21, 32'h2, 32'h0, 32'h12348765, 1, 1, 0);
        checkOutput("lh_lit", cap_ld, 32'hFFFF8765);
        applyStimulus(6'h25, 32'h0, 32'h0, 32'h87651234, 0, 0, 0);
        applyStimulus(6'h28, 32'h1, 32'h00000055, 32'h0, 2, 1, 0);
        checkOutput("sb_be_lit", 32'(cap_be), 32'h4);
        applyStimulus(6'h00, 32'h8, 32'h0, 32'h0, 0, 1, 0);
        applyStimulus(6'h2B, 32'h2, 32'h0, 32'h0, 0, 1, 0);
        applyStimulus(6'h23, 32'hFFC, 32'h0, 32'hCAFEF00D, TIMEOUT - 1, 1, 0);

        $display("[TB] LW timeout with late ack");
        clearCounts();
        applyStimulus(6'h23, 32'h20, 32'h0, 32'h11111111, -1, 3, 2);
        checkOutput("tmo_bus_err", 32'(bus_count), 32'd1);
        checkOutput("tmo_req_cycles", 32'(req_cycles), 32'd16);
        checkOutput("tmo_ld_lit", ld_data, 32'h0);

        $display("[TB] reset during REQ");
        applyStimulus(6'h23, 32'h4, 32'h0, 32'h12345678, 0, 1, 0);
        clearCounts();
        step();
        in_valid = 1'b1; Ins = {6'h23, 26'h0}; Result = 32'h8; mem_ack = 1'b0;
        idleExp(); e_stall = 1'b1;
        step();
        RST = 1'b1;
        e_stall = 1'b1; e_req = 1'b1; e_addr = 10'd2; e_we = 1'b0; e_be = 4'hF; e_wdata = 32'h0;
        step();
        RST = 1'b0; in_valid = 1'b0;
        idleExp(); e_ld = 32'h0;
        step();
        idleExp();
        checkOutput("rst_mid_no_ldv", 32'(ldv_count), 32'd0);

        $display("[TB] back-to-back LW");
        clearCounts();
        applyStimulus(6'h23, 32'h0, 32'h0, 32'hA5A5A5A5, 3, 0, 0);
        applyStimulus(6'h23, 32'h4, 32'h0, 32'h5A5A5A5A, 3, 1, 0);
        checkOutput("b2b_ldv", 32'(ldv_count), 32'd2);
        checkOutput("b2b_last_addr", 32'(cap_addr), 32'h1);
        checkOutput("b2b_ld_lit", cap_ld, 32'h5A5A5A5A);

        step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
